// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame-to-AXI4-Stream path.
// Used by frame_axis_streamer and frame_stream_skid.
package frame_stream_pkg;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_STREAM = 2'd1,
        FS_DRAIN  = 2'd2
    } fs_state_t;

    localparam int FS_BUF_DEPTH = 2;
    localparam int FS_CNT_W     = $clog2(FS_BUF_DEPTH + 1);

    function automatic bit fs_axis_width_ok(input int axis_width, input int data_size);
        return ((axis_width % 8) == 0) && (axis_width >= data_size);
    endfunction

endpackage

// File: rtl/frame_stream_skid.sv
// Two-entry output buffer holding sample data plus its tlast (and, with
// FRAME_STREAM_TUSER_EN, tuser) tag; entry 0 is always the presented beat.
module frame_stream_skid
    import frame_stream_pkg::*;
#(
    parameter int DATA_SIZE = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic                 trim,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 push_last,
`ifdef FRAME_STREAM_TUSER_EN
    input  logic                 push_user,
    output logic                 head_user,
`endif
    output logic [FS_CNT_W-1:0]  count,
    output logic [DATA_SIZE-1:0] head_data,
    output logic                 head_last
);

`ifdef FRAME_STREAM_TUSER_EN
    localparam int EW = DATA_SIZE + 2;
`else
    localparam int EW = DATA_SIZE + 1;
`endif

    logic [EW-1:0] in_ent;
    logic [EW-1:0] ent0_p1;
    logic [EW-1:0] ent1_p1;

`ifdef FRAME_STREAM_TUSER_EN
    assign in_ent = {push_user, push_last, push_data};
    assign {head_user, head_last, head_data} = ent0_p1;
`else
    assign in_ent = {push_last, push_data};
    assign {head_last, head_data} = ent0_p1;
`endif

    // flush drops everything, trim keeps only the beat being presented
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent0_p1 <= '0;
            ent1_p1 <= '0;
            count   <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (trim) begin
            if (count != '0) count <= FS_CNT_W'(1);
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == '0) ent0_p1 <= in_ent;
                    else             ent1_p1 <= in_ent;
                    count <= count + FS_CNT_W'(1);
                end
                2'b01: begin
                    ent0_p1 <= ent1_p1;
                    count   <= count - FS_CNT_W'(1);
                end
                2'b11: begin
                    if (count == FS_CNT_W'(2)) begin
                        ent0_p1 <= ent1_p1;
                        ent1_p1 <= in_ent;
                    end else begin
                        ent0_p1 <= in_ent;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_axis_streamer.sv
// Streams a finished frame from the frame RAM as an AXI4-Stream master with
// backpressure and abort. Define FRAME_STREAM_TUSER_EN to add m_axis_tuser.
module frame_axis_streamer
    import frame_stream_pkg::*;
#(
    parameter int DATA_SIZE   = 12,
    parameter int LENGTH      = 32768,
    parameter int LENGTH_SIZE = 15,
    parameter int AXIS_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LENGTH_SIZE-1:0]  frame_len,
    output logic                    rd_en,
    output logic [LENGTH_SIZE-1:0]  rd_addr,
    input  logic [DATA_SIZE-1:0]    rd_data,
    output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
`ifdef FRAME_STREAM_TUSER_EN
    output logic                    m_axis_tuser,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [15:0]             frame_cnt
);

    if (!fs_axis_width_ok(AXIS_WIDTH, DATA_SIZE)) begin : g_bad_width
        $error("frame_axis_streamer: AXIS_WIDTH must be a multiple of 8 and >= DATA_SIZE");
    end
    if ((2 ** LENGTH_SIZE) != LENGTH) begin : g_bad_length
        $error("frame_axis_streamer: LENGTH must equal 2**LENGTH_SIZE");
    end

    fs_state_t              state;
    logic [LENGTH_SIZE-1:0] len_lat;
    logic                   abort_q;
    logic                   vld_p1;
    logic                   last_p1;
    logic [FS_CNT_W-1:0]    buf_count;
    logic [DATA_SIZE-1:0]   head_data;
    logic                   head_last;
    logic                   hs;
    logic                   stall;
    logic                   abort_act;
    logic                   room;

    assign busy      = (state != FS_IDLE);
    assign abort_act = abort && busy;
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign stall     = m_axis_tvalid && !m_axis_tready;

    // Issue a read only if the buffer can still absorb it after this cycle's pop.
    assign room  = (3'(buf_count) + 3'(vld_p1)) < (3'(FS_BUF_DEPTH) + 3'(hs));
    assign rd_en = (state == FS_STREAM) && !abort && room;

    assign m_axis_tvalid = (buf_count != '0);
    assign m_axis_tdata  = AXIS_WIDTH'(head_data);
    assign m_axis_tkeep  = {(AXIS_WIDTH/8){m_axis_tvalid}};
    assign m_axis_tlast  = m_axis_tvalid && (head_last || abort_q || abort_act);

`ifdef FRAME_STREAM_TUSER_EN
    logic user_p1;
    logic head_user;
    assign m_axis_tuser = m_axis_tvalid && head_user;
`endif

    frame_stream_skid #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (vld_p1 && !abort_act),
        .pop       (hs),
        .flush     (abort_act && !stall),
        .trim      (abort_act && stall),
        .push_data (rd_data),
        .push_last (last_p1),
`ifdef FRAME_STREAM_TUSER_EN
        .push_user (user_p1),
        .head_user (head_user),
`endif
        .count     (buf_count),
        .head_data (head_data),
        .head_last (head_last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FS_IDLE;
            len_lat   <= '0;
            rd_addr   <= '0;
            abort_q   <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
`ifdef FRAME_STREAM_TUSER_EN
            user_p1   <= 1'b0;
`endif
            aborted   <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done    <= 1'b0;
            // read issue -> data returning from RAM
            vld_p1  <= rd_en;
            last_p1 <= rd_en && (rd_addr == len_lat);
`ifdef FRAME_STREAM_TUSER_EN
            user_p1 <= rd_en && (rd_addr == '0);
`endif
            if (rd_en) rd_addr <= rd_addr + LENGTH_SIZE'(1);

            unique case (state)
                FS_IDLE: begin
                    if (start && !abort && !done) begin
                        state   <= FS_STREAM;
                        len_lat <= frame_len;
                        rd_addr <= '0;
                        aborted <= 1'b0;
                    end
                end
                default: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        vld_p1  <= 1'b0;
                        if (stall) begin
                            state   <= FS_DRAIN;
                            abort_q <= 1'b1;
                        end else begin
                            state   <= FS_IDLE;
                            abort_q <= 1'b0;
                        end
                    end else if (state == FS_STREAM) begin
                        if (rd_en && (rd_addr == len_lat)) state <= FS_DRAIN;
                    end else if (hs && m_axis_tlast) begin
                        state   <= FS_IDLE;
                        abort_q <= 1'b0;
                        if (!abort_q) begin
                            done      <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_axis_streamer.sv
// Directed bench for frame_axis_streamer: cycle-table for the basic frame,
// hand sequences for backpressure, single-beat, abort and reset cases.
module tb_frame_axis_streamer;

    localparam int DATA_SIZE   = 12;
    localparam int LENGTH      = 32768;
    localparam int LENGTH_SIZE = 15;
    localparam int AXIS_WIDTH  = 32;
    localparam int KEEP_W      = AXIS_WIDTH / 8;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic [LENGTH_SIZE-1:0] frame_len = '0;
    logic                   rd_en;
    logic [LENGTH_SIZE-1:0] rd_addr;
    logic [DATA_SIZE-1:0]   rd_data = '0;
    logic [AXIS_WIDTH-1:0]  m_axis_tdata;
    logic [KEEP_W-1:0]      m_axis_tkeep;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready = 1'b0;
    logic                   m_axis_tlast;
`ifdef FRAME_STREAM_TUSER_EN
    logic                   m_axis_tuser;
`endif
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic [15:0]            frame_cnt;

    logic [DATA_SIZE-1:0]   ram_base = 12'h100;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= ram_base + DATA_SIZE'(rd_addr);

    frame_axis_streamer #(
        .DATA_SIZE   (DATA_SIZE),
        .LENGTH      (LENGTH),
        .LENGTH_SIZE (LENGTH_SIZE),
        .AXIS_WIDTH  (AXIS_WIDTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .abort         (abort),
        .frame_len     (frame_len),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
`ifdef FRAME_STREAM_TUSER_EN
        .m_axis_tuser  (m_axis_tuser),
`endif
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .frame_cnt     (frame_cnt)
    );

    typedef struct {
        bit start;
        bit busy;
        bit rd_en;
        int addr;
        bit tvalid;
        int tdata;
        bit tlast;
        bit done;
        int cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(bit s, bit b, bit re, int a, bit tv, int td, bit tl, bit dn, int cnt);
        vec_t v;
        v.start = s; v.busy = b; v.rd_en = re; v.addr = a; v.tvalid = tv;
        v.tdata = td; v.tlast = tl; v.done = dn; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then sample 1 ns later.
    task automatic tick(input logic s, input logic tr, input logic ab);
        @(negedge clk);
        start = s;
        m_axis_tready = tr;
        abort = ab;
        #1;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},  32'(rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_tdata"},  m_axis_tdata, 32'd0);
        check({tag, "_tkeep"},  32'(m_axis_tkeep), 32'd0);
        check({tag, "_tlast"},  32'(m_axis_tlast), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_done"},   32'(done), 32'd0);
        check({tag, "_aborted"}, 32'(aborted), 32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
`ifdef FRAME_STREAM_TUSER_EN
        check({tag, "_tuser"},  32'(m_axis_tuser), 32'd0);
`endif
    endtask

    initial begin
        bit got;
        int reads;
        int beats;
        bit prev_stall;
        logic [31:0] prev_tdata;
        logic prev_tlast;

        // frame_len = 7, RAM[i] = 0x100 + i, tready high; start retried on done and after
        //            start busy rd  addr tv  tdata  tl dn cnt
        vecs[0]  = mk(1,    0,   0,  0,   0,  0,     0, 0, 0);
        vecs[1]  = mk(0,    1,   1,  0,   0,  0,     0, 0, 0);
        vecs[2]  = mk(0,    1,   1,  1,   0,  0,     0, 0, 0);
        vecs[3]  = mk(0,    1,   1,  2,   1,  'h100, 0, 0, 0);
        vecs[4]  = mk(0,    1,   1,  3,   1,  'h101, 0, 0, 0);
        vecs[5]  = mk(0,    1,   1,  4,   1,  'h102, 0, 0, 0);
        vecs[6]  = mk(0,    1,   1,  5,   1,  'h103, 0, 0, 0);
        vecs[7]  = mk(0,    1,   1,  6,   1,  'h104, 0, 0, 0);
        vecs[8]  = mk(0,    1,   1,  7,   1,  'h105, 0, 0, 0);
        vecs[9]  = mk(0,    1,   0,  0,   1,  'h106, 0, 0, 0);
        vecs[10] = mk(0,    1,   0,  0,   1,  'h107, 1, 0, 0);
        vecs[11] = mk(1,    0,   0,  0,   0,  0,     0, 1, 1);
        vecs[12] = mk(1,    0,   0,  0,   0,  0,     0, 0, 1);
        vecs[13] = mk(0,    1,   1,  0,   0,  0,     0, 0, 1);

        // Reset state
        #1;
        check_all_zero("rst");
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rstn = 1'b1;

        // Test 1: table-driven basic frame
        frame_len = 15'd7;
        ram_base  = 12'h100;
        for (int c = 0; c < 14; c++) begin
            tick(vecs[c].start, 1'b1, 1'b0);
            check($sformatf("t1_c%0d_busy", c),   32'(busy),          32'(vecs[c].busy));
            check($sformatf("t1_c%0d_rd_en", c),  32'(rd_en),         32'(vecs[c].rd_en));
            if (vecs[c].rd_en)
                check($sformatf("t1_c%0d_rd_addr", c), 32'(rd_addr), vecs[c].addr);
            check($sformatf("t1_c%0d_tvalid", c), 32'(m_axis_tvalid), 32'(vecs[c].tvalid));
            check($sformatf("t1_c%0d_tlast", c),  32'(m_axis_tlast),  32'(vecs[c].tlast));
            if (vecs[c].tvalid) begin
                check($sformatf("t1_c%0d_tdata", c), m_axis_tdata, vecs[c].tdata);
                check($sformatf("t1_c%0d_tkeep", c), 32'(m_axis_tkeep), 32'hF);
            end
            check($sformatf("t1_c%0d_done", c),   32'(done),          32'(vecs[c].done));
            check($sformatf("t1_c%0d_cnt", c),    32'(frame_cnt),     vecs[c].cnt);
`ifdef FRAME_STREAM_TUSER_EN
            check($sformatf("t1_c%0d_tuser", c), 32'(m_axis_tuser), 32'(c == 3));
`endif
        end
        wait_done(40, got);
        check("t1_frame2_done", 32'(got), 32'd1);
        check("t1_frame2_cnt", 32'(frame_cnt), 32'd2);
        check("t1_aborted", 32'(aborted), 32'd0);

        // Test 2: frame_len = 15 with random backpressure
        frame_len = 15'd15;
        ram_base  = 12'h200;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        reads = 0; beats = 0; got = 1'b0; prev_stall = 1'b0;
        prev_tdata = '0; prev_tlast = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (prev_stall) begin
                check("t2_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("t2_hold_tdata", m_axis_tdata, prev_tdata);
                check("t2_hold_tlast", 32'(m_axis_tlast), 32'(prev_tlast));
            end
            if (rd_en) begin
                check("t2_rd_addr", 32'(rd_addr), reads);
                reads++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("t2_beat_tdata", m_axis_tdata, 32'h200 + beats);
                check("t2_beat_tlast", 32'(m_axis_tlast), 32'(beats == 15));
`ifdef FRAME_STREAM_TUSER_EN
                check("t2_beat_tuser", 32'(m_axis_tuser), 32'(beats == 0));
`endif
                beats++;
            end
            check("t2_reads_ahead", 32'(reads - beats <= 2), 32'd1);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_tdata = m_axis_tdata;
            prev_tlast = m_axis_tlast;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("t2_done_seen", 32'(got), 32'd1);
        check("t2_beats", beats, 32'd16);
        check("t2_reads", reads, 32'd16);
        check("t2_cnt", 32'(frame_cnt), 32'd3);

        // Test 3: single-beat frame
        frame_len = 15'd0;
        ram_base  = 12'hA5C;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("t3_c1_rd_en", 32'(rd_en), 32'd1);
        check("t3_c1_rd_addr", 32'(rd_addr), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check("t3_c2_rd_en", 32'(rd_en), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check("t3_c3_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t3_c3_tdata", m_axis_tdata, 32'hA5C);
        check("t3_c3_tlast", 32'(m_axis_tlast), 32'd1);
`ifdef FRAME_STREAM_TUSER_EN
        check("t3_c3_tuser", 32'(m_axis_tuser), 32'd1);
`endif
        tick(1'b0, 1'b1, 1'b0);
        check("t3_c4_done", 32'(done), 32'd1);
        check("t3_c4_busy", 32'(busy), 32'd0);
        check("t3_c4_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t3_c4_cnt", 32'(frame_cnt), 32'd4);

        // Test 4: abort while beat 5 is stalled
        frame_len = 15'd9;
        ram_base  = 12'h300;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int c = 1; c < 8; c++) tick(1'b0, 1'b1, 1'b0);
        check("t4_c7_beat4", m_axis_tdata, 32'h304);
        check("t4_c7_tlast", 32'(m_axis_tlast), 32'd0);
        tick(1'b0, 1'b0, 1'b1);
        check("t4_c8_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t4_c8_tdata", m_axis_tdata, 32'h305);
        check("t4_c8_tlast", 32'(m_axis_tlast), 32'd1);
        check("t4_c8_rd_en", 32'(rd_en), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check("t4_c9_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t4_c9_tdata", m_axis_tdata, 32'h305);
        check("t4_c9_tlast", 32'(m_axis_tlast), 32'd1);
        check("t4_c9_rd_en", 32'(rd_en), 32'd0);
        check("t4_c9_aborted", 32'(aborted), 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        check("t4_c10_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t4_c10_tdata", m_axis_tdata, 32'h305);
        for (int c = 11; c < 15; c++) begin
            tick(1'b0, 1'b1, 1'b0);
            check($sformatf("t4_c%0d_tvalid", c), 32'(m_axis_tvalid), 32'd0);
            check($sformatf("t4_c%0d_done", c), 32'(done), 32'd0);
            check($sformatf("t4_c%0d_busy", c), 32'(busy), 32'd0);
        end
        check("t4_aborted", 32'(aborted), 32'd1);
        check("t4_cnt", 32'(frame_cnt), 32'd4);

        // Test 4b: abort before any beat is presented
        frame_len = 15'd5;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("t4b_c2_tvalid", 32'(m_axis_tvalid), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        check("t4b_c3_busy", 32'(busy), 32'd0);
        check("t4b_c3_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t4b_c3_aborted", 32'(aborted), 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        check("t4b_c4_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t4b_c4_cnt", 32'(frame_cnt), 32'd4);

        // Test 5: start while busy, then reset mid-frame
        frame_len = 15'd7;
        ram_base  = 12'h100;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("t5_c1_aborted_clr", 32'(aborted), 32'd0);
        for (int c = 2; c < 5; c++) tick(1'b0, 1'b1, 1'b0);
        frame_len = 15'd2;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("t5_c6_rd_en", 32'(rd_en), 32'd1);
        check("t5_c6_rd_addr", 32'(rd_addr), 32'd5);
        check("t5_c6_tdata", m_axis_tdata, 32'h103);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_all_zero("t5_rst");
        tick(1'b0, 1'b1, 1'b0);
        check_all_zero("t5_rst_hold");
        @(negedge clk);
        rstn = 1'b1;
        frame_len = 15'd3;
        ram_base  = 12'h050;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("t5f_c1_rd_en", 32'(rd_en), 32'd1);
        check("t5f_c1_rd_addr", 32'(rd_addr), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        for (int c = 3; c < 7; c++) begin
            tick(1'b0, 1'b1, 1'b0);
            check($sformatf("t5f_c%0d_tvalid", c), 32'(m_axis_tvalid), 32'd1);
            check($sformatf("t5f_c%0d_tdata", c), m_axis_tdata, 32'h050 + (c - 3));
            check($sformatf("t5f_c%0d_tlast", c), 32'(m_axis_tlast), 32'(c == 6));
        end
        tick(1'b0, 1'b1, 1'b0);
        check("t5f_c7_done", 32'(done), 32'd1);
        check("t5f_c7_cnt", 32'(frame_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
